// File: rtl/video_pattern_source.sv
// ---------------------------------------------------------------------------
// video_pattern_source
//   AXI4-Stream video master that emits complete frames of a deterministic
//   colour ramp. The first beat of a frame carries tuser (SOF), and the last
//   pixel of each line carries tlast (EOL). A programmable idle gap separates
//   frames. The block serves as an on-chip stimulus source and as a bring-up
//   bypass for the camera input path.
//
// Ports
//   aclk, aresetn          clock; synchronous active-low reset
//   aclken                 clock enable; when low, every register holds
//   enable                 frame request, sampled only at frame boundaries
//   seed_rgb[23:0]         {r,g,b} of the first pixel, sampled at frame start
//   m_axis_video_*         AXI4-Stream master (tdata/tvalid/tready/tuser/tlast)
//   frame_done             one-cycle pulse after the final beat of a frame
//   frame_count[15:0]      number of completed frames, wraps
//
// Handshake: a beat transfers on a rising aclk edge where tvalid, tready and
// aclken are all high. tvalid is a pure register output with no path from
// tready. Once tvalid is raised inside a frame, it stays high until a
// transfer. tdata, tuser and tlast are held stable while the beat waits.
// ---------------------------------------------------------------------------
module video_pattern_source #(
  parameter int FRAME_W      = 1920,
  parameter int FRAME_H      = 1080,
  parameter int DATA_W       = 64,
  parameter int BLANK_CYCLES = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              aclken,
  input  logic              enable,
  input  logic [23:0]       seed_rgb,
  output logic [DATA_W-1:0] m_axis_video_tdata,
  output logic              m_axis_video_tvalid,
  input  logic              m_axis_video_tready,
  output logic              m_axis_video_tuser,
  output logic              m_axis_video_tlast,
  output logic              frame_done,
  output logic [15:0]       frame_count
);

  localparam int XW = $clog2(FRAME_W);
  localparam int YW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [XW-1:0] X_LAST     = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(FRAME_H - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_BLANK  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [7:0]          r_q, r_d, g_q, g_d, b_q, b_d;
  logic [BW-1:0]       blank_cnt_q, blank_cnt_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tuser_q, tuser_d;
  logic                tlast_q, tlast_d;
  logic                frame_done_q, frame_done_d;
  logic [15:0]         frame_count_q, frame_count_d;
  logic                fire;
  logic                start_frame;

  // aclken gating lives in the register process, so a tready seen while
  // aclken is low never advances anything.
  assign fire = tvalid_q & m_axis_video_tready;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    r_d           = r_q;
    g_d           = g_q;
    b_d           = b_q;
    blank_cnt_d   = blank_cnt_q;
    frame_done_d  = 1'b0;
    frame_count_d = frame_count_q;
    start_frame   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) start_frame = 1'b1;
      end
      ST_ACTIVE: begin
        if (fire) begin
          r_d = r_q - 8'd1;
          g_d = g_q + 8'd1;
          b_d = b_q - 8'd2;
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d           = '0;
              frame_done_d  = 1'b1;
              frame_count_d = frame_count_q + 16'd1;
              if (BLANK_CYCLES > 0) begin
                state_d     = ST_BLANK;
                blank_cnt_d = '0;
              end else if (enable) begin
                start_frame = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ST_BLANK: begin
        if (blank_cnt_q == BLANK_LAST) begin
          if (enable) start_frame = 1'b1;
          else        state_d     = ST_IDLE;
        end else begin
          blank_cnt_d = blank_cnt_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Frame boundaries are the only place the seed and enable take effect.
    if (start_frame) begin
      state_d = ST_ACTIVE;
      x_d     = '0;
      y_d     = '0;
      r_d     = seed_rgb[23:16];
      g_d     = seed_rgb[15:8];
      b_d     = seed_rgb[7:0];
    end

    // Outputs are registered from next-state values. The presented beat then
    // always matches the x/y/colour registers.
    tvalid_d          = (state_d == ST_ACTIVE);
    tuser_d           = tvalid_d && (x_d == '0) && (y_d == '0);
    tlast_d           = tvalid_d && (x_d == X_LAST);
    tdata_d           = '0;
    tdata_d[29:22]    = r_d;
    tdata_d[19:12]    = b_d;
    tdata_d[9:2]      = g_d;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q       <= ST_IDLE;
      x_q           <= '0;
      y_q           <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      blank_cnt_q   <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tuser_q       <= 1'b0;
      tlast_q       <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else if (aclken) begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      blank_cnt_q   <= blank_cnt_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tuser_q       <= tuser_d;
      tlast_q       <= tlast_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign m_axis_video_tdata  = tdata_q;
  assign m_axis_video_tvalid = tvalid_q;
  assign m_axis_video_tuser  = tuser_q;
  assign m_axis_video_tlast  = tlast_q;
  assign frame_done          = frame_done_q;
  assign frame_count         = frame_count_q;

endmodule

// File: tb/tb_video_pattern_source.sv
// ---------------------------------------------------------------------------
// tb_video_pattern_source
//   Directed bench for video_pattern_source using 8x2 frames. The main
//   instance has a 4-cycle blanking gap. A second instance has no gap and
//   checks back-to-back frames.
// ---------------------------------------------------------------------------
module tb_video_pattern_source;

  localparam int W  = 8;
  localparam int H  = 2;
  localparam int BL = 4;

  // clock / reset
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn, aclken, enable, tready;
  logic [23:0] seed_rgb;
  logic [63:0] tdata;
  logic        tvalid, tuser, tlast, frame_done;
  logic [15:0] frame_count;

  logic        aresetn_z, enable_z, tready_z;
  logic [23:0] seed_z;
  logic [63:0] tdata_z;
  logic        tvalid_z, tuser_z, tlast_z, frame_done_z;
  logic [15:0] frame_count_z;

  video_pattern_source #(.FRAME_W(W), .FRAME_H(H), .DATA_W(64), .BLANK_CYCLES(BL)) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .enable(enable), .seed_rgb(seed_rgb),
    .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid), .m_axis_video_tready(tready),
    .m_axis_video_tuser(tuser), .m_axis_video_tlast(tlast),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  video_pattern_source #(.FRAME_W(W), .FRAME_H(H), .DATA_W(64), .BLANK_CYCLES(0)) dut_z (
    .aclk(aclk), .aresetn(aresetn_z), .aclken(1'b1), .enable(enable_z), .seed_rgb(seed_z),
    .m_axis_video_tdata(tdata_z), .m_axis_video_tvalid(tvalid_z), .m_axis_video_tready(tready_z),
    .m_axis_video_tuser(tuser_z), .m_axis_video_tlast(tlast_z),
    .frame_done(frame_done_z), .frame_count(frame_count_z)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    pack = (64'(r) << 22) | (64'(b) << 12) | (64'(g) << 2);
  endfunction

  // Expected pixel n of a frame: r-n, g+n, b-2n modulo 256.
  function automatic logic [63:0] pix(input logic [23:0] seed, input int n);
    logic [7:0] r, g, b;
    r = seed[23:16] - 8'(n);
    g = seed[15:8]  + 8'(n);
    b = seed[7:0]   - 8'(2 * n);
    pix = pack(r, g, b);
  endfunction

  // Outputs are sampled on the falling edge and inputs change there too.
  task automatic tick();
    @(negedge aclk);
  endtask

  task automatic chk_beat(input string tag, input logic [23:0] seed, input int n);
    chk($sformatf("%s_b%0d_tvalid", tag, n), 64'(tvalid), 64'd1);
    chk($sformatf("%s_b%0d_tdata", tag, n), tdata, pix(seed, n));
    chk($sformatf("%s_b%0d_tuser", tag, n), 64'(tuser), 64'(n == 0));
    chk($sformatf("%s_b%0d_tlast", tag, n), 64'(tlast), 64'((n % W) == W - 1));
  endtask

  initial begin
    int gap;
    aresetn = 1'b0; aclken = 1'b1; enable = 1'b0; tready = 1'b1; seed_rgb = 24'hFFFFFF;
    aresetn_z = 1'b0; enable_z = 1'b0; tready_z = 1'b1; seed_z = 24'h00FF80;
    tick(); tick();

    // Reset values
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata", tdata, 64'd0);
    chk("rst_tuser", 64'(tuser), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);

    // Frame 1: seed FFFFFF, full throughput, one cycle of enable latency
    aresetn = 1'b1; enable = 1'b1;
    tick();
    chk("f1_beat0_lit", tdata, 64'h3FCF_F3FC);
    for (int n = 0; n < W * H; n++) begin
      chk_beat("f1", 24'hFFFFFF, n);
      if (n == 1) chk("f1_beat1_lit", tdata, 64'h3F8F_D000);
      tick();
    end
    chk("f1_frame_done", 64'(frame_done), 64'd1);
    chk("f1_frame_count", 64'(frame_count), 64'd1);
    chk("f1_blank_tvalid", 64'(tvalid), 64'd0);

    // Blank gap between frames
    gap = 1;
    for (int i = 0; i < 20 && tvalid !== 1'b1; i++) begin
      tick();
      if (tvalid !== 1'b1) gap++;
    end
    chk("gap_len", 64'(gap), 64'(BL));
    chk("gap_frame_done_low", 64'(frame_done), 64'd0);

    // Frame 2: the seed changes mid-frame but is ignored until the next frame
    seed_rgb = 24'h123456;
    for (int n = 0; n < 3; n++) begin
      chk_beat("f2", 24'hFFFFFF, n);
      tick();
    end
    tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp%0d_tvalid", i), 64'(tvalid), 64'd1);
      chk($sformatf("bp%0d_tdata", i), tdata, 64'h3F0F_9008);
      chk($sformatf("bp%0d_tuser", i), 64'(tuser), 64'd0);
      chk($sformatf("bp%0d_tlast", i), 64'(tlast), 64'd0);
    end
    tready = 1'b1;
    chk_beat("f2", 24'hFFFFFF, 3);
    tick();
    chk_beat("f2", 24'hFFFFFF, 4);
    tick();
    // aclken low with tready high: nothing may move
    aclken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_beat($sformatf("ce%0d", i), 24'hFFFFFF, 5);
    end
    aclken = 1'b1;
    for (int n = 5; n < W * H; n++) begin
      chk_beat("f2", 24'hFFFFFF, n);
      tick();
    end
    chk("f2_frame_done", 64'(frame_done), 64'd1);
    chk("f2_frame_count", 64'(frame_count), 64'd2);
    for (int i = 0; i < BL; i++) tick();

    // Frame 3 uses the new seed. Enable is dropped after beat 5, but the frame
    // still completes.
    chk("f3_beat0_lit", tdata, 64'h0485_60D0);
    for (int n = 0; n < W * H; n++) begin
      chk_beat("f3", 24'h123456, n);
      tick();
      if (n == 5) enable = 1'b0;
    end
    chk("f3_frame_done", 64'(frame_done), 64'd1);
    chk("f3_frame_count", 64'(frame_count), 64'd3);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("idle%0d_tvalid", i), 64'(tvalid), 64'd0);
      tick();
    end
    chk("idle_frame_count", 64'(frame_count), 64'd3);

    // Reset in the middle of a frame
    seed_rgb = 24'hA0B0C0; enable = 1'b1;
    tick();
    for (int n = 0; n < 10; n++) begin
      chk_beat("f4", 24'hA0B0C0, n);
      tick();
    end
    aresetn = 1'b0;
    tick();
    chk("mrst_tvalid", 64'(tvalid), 64'd0);
    chk("mrst_tdata", tdata, 64'd0);
    chk("mrst_frame_count", 64'(frame_count), 64'd0);
    aresetn = 1'b1;
    tick();
    for (int n = 0; n < W * H; n++) begin
      chk_beat("f5", 24'hA0B0C0, n);
      tick();
    end
    chk("f5_frame_count", 64'(frame_count), 64'd1);
    chk("f5_frame_done", 64'(frame_done), 64'd1);
    enable = 1'b0;

    // No blanking: frames run back to back
    aresetn_z = 1'b1; enable_z = 1'b1;
    tick();
    for (int n = 0; n < 2 * W * H; n++) begin
      chk($sformatf("z_b%0d_tvalid", n), 64'(tvalid_z), 64'd1);
      chk($sformatf("z_b%0d_tdata", n), tdata_z, pix(seed_z, n % (W * H)));
      chk($sformatf("z_b%0d_tuser", n), 64'(tuser_z), 64'((n % (W * H)) == 0));
      chk($sformatf("z_b%0d_tlast", n), 64'(tlast_z), 64'((n % W) == W - 1));
      if (n == W * H) begin
        chk("z_frame_done", 64'(frame_done_z), 64'd1);
        chk("z_frame_count1", 64'(frame_count_z), 64'd1);
      end
      tick();
    end
    chk("z_frame_count2", 64'(frame_count_z), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
